// File: rtl/uart_rx_fifo_if.sv
// Receive-byte stream between the UART receiver and its consumer.
// The receiver drives the head entry and its valid flag; the consumer answers with ready.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_data_valid;
  logic                 rx_data_ready;

  modport master (
    output rx_data,
    output rx_parity_err,
    output rx_frame_err,
    output rx_data_valid,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_data_valid,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, parity/framing/break detection and a
// show-ahead receive FIFO that flags overrun when a frame has to be dropped.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DIV_W       = 21,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              cycle,
  input  logic [1:0]                    parity_mode,
  input  logic                          rx_pin,
  uart_rx_fifo_if.master                rx,
  output logic                          rx_break,
  output logic                          rx_overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam int unsigned EntW = DATA_BITS + 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  // Input synchroniser; resets to the idle-high level so reset never fakes an edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_prev_q;
  logic                   line;
  logic                   start_edge;

  assign line       = sync_q[SYNC_STAGES-1];
  assign start_edge = line_prev_q & ~line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      line_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_pin};
      line_prev_q <= line;
    end
  end

  state_e               state_q;
  logic [DIV_W-1:0]     per_q;
  logic [DIV_W-1:0]     cnt_q;
  logic [1:0]           pm_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IdxW-1:0]      idx_q;
  logic                 par_bit_q;
  logic                 perr_q;
  logic                 break_q;

  logic tick;
  logic parity_on;
  logic par_xor;
  logic all_zero;

  assign tick      = (cnt_q == '0);
  assign parity_on = (pm_q == 2'b01) || (pm_q == 2'b10);
  assign par_xor   = (^shift_q) ^ line;
  assign all_zero  = (shift_q == '0) && !par_bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      per_q     <= '0;
      cnt_q     <= '0;
      pm_q      <= 2'b00;
      shift_q   <= '0;
      idx_q     <= '0;
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      break_q <= 1'b0;
      if (state_q != StIdle && state_q != StWaitHigh) begin
        cnt_q <= tick ? (per_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
      end
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            per_q     <= cycle;
            pm_q      <= parity_mode;
            cnt_q     <= cycle >> 1;
            perr_q    <= 1'b0;
            par_bit_q <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          idx_q <= '0;
          if (tick) begin
            state_q <= line ? StIdle : StData;
          end
        end
        StData: begin
          if (tick) begin
            shift_q <= {line, shift_q[DATA_BITS-1:1]};
            if (idx_q == LastIdx) begin
              state_q <= parity_on ? StParity : StStop;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StParity: begin
          if (tick) begin
            par_bit_q <= line;
            perr_q    <= (pm_q == 2'b01) ? par_xor : ~par_xor;
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (tick) begin
            if (line) begin
              state_q <= StIdle;
            end else begin
              break_q <= all_zero;
              state_q <= StWaitHigh;
            end
          end
        end
        StWaitHigh: begin
          if (line) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Frames are written straight from the stop sample; a break writes nothing.
  logic push;
  logic push_ferr;

  assign push      = tick && (state_q == StStop) && (line || !all_zero);
  assign push_ferr = ~line;

  logic [EntW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic [CntW-1:0] count_q;
  logic            overrun_q;

  logic pop;
  logic full;
  logic do_push;
  logic drop;

  assign pop     = (count_q != '0) && rx.rx_data_ready;
  assign full    = (count_q == Depth);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= {push_ferr, perr_q, shift_q};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      unique case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
    end
  end

  logic [EntW-1:0] head;
  assign head = mem_q[rd_q];

  assign rx.rx_data       = head[DATA_BITS-1:0];
  assign rx.rx_parity_err = head[DATA_BITS];
  assign rx.rx_frame_err  = head[DATA_BITS+1];
  assign rx.rx_data_valid = (count_q != '0);
  assign rx_break         = break_q;
  assign rx_overrun       = overrun_q;
  assign fifo_count       = count_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver for the support library. It handles 5–9 data bits, runtime-selectable parity, mid-bit sampling with false-start rejection, framing/parity/break detection, and a small receive FIFO with overrun flagging. It sits between the board serial pin and any byte-stream consumer, driven by the same runtime bit-period input `cycle`.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `DIV_W`, default 21: width of `cycle`.
- `FIFO_DEPTH`, default 4: entries; must be a power of 2, ≥ 2.
- `SYNC_STAGES`, default 2: input synchroniser flops, ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cycle` in DIV_W: clocks per bit; legal ≥ 4.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none.
- `rx_pin` in 1: serial input, idle high.
- `rx_data` out DATA_BITS: FIFO head data, LSB = first received bit.
- `rx_parity_err` out 1: head entry parity error.
- `rx_frame_err` out 1: head entry stop-bit error.
- `rx_data_valid` out 1: FIFO non-empty.
- `rx_data_ready` in 1: consumer pops head when valid & ready.
- `rx_break` out 1: one-cycle pulse on break detection.
- `rx_overrun` out 1: sticky; a frame was dropped because the FIFO was full.
- `clr_overrun` in 1: clears `rx_overrun`.
- `fifo_count` out clog2(FIFO_DEPTH)+1: occupied entries.

## Operation
- `rx_pin` passes through a SYNC_STAGES synchroniser (flops reset to 1) and one edge flop. A start edge is sync high→low.
- States are IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on the start edge, latch `cycle` into `per` and `parity_mode` into `pm`, load `cnt = per>>1`, then go to START. Mid-frame changes to the inputs have no effect.
- Counter: decrements every clock. When it reaches 0, sample the synced line, reload `cnt = per-1`, and take the transition. Samples are therefore `per` clocks apart.
- START sample high: false start. Discard and return to IDLE; no flags.
- START sample low: go to DATA with bit index 0.
- DATA: shift in LSB-first. After bit DATA_BITS-1, go to PARITY if `pm` is 01 or 10, otherwise go to STOP.
- PARITY check:
  - Even: the XOR of the data bits and the parity bit must be 0.
  - Odd: that XOR must be 1.
  - A mismatch sets `perr`.
- STOP sample high:
  - Push {ferr=0, perr, data}.
  - Go to IDLE the same cycle, so a start edge one clock later is accepted.
- STOP sample low, with data all zero and the parity bit (if any) zero:
  - Break: pulse `rx_break` and push nothing.
  - Go to WAIT_HIGH.
- STOP sample low, otherwise:
  - Push {ferr=1, perr, data}.
  - Go to WAIT_HIGH.
- WAIT_HIGH: stay until the synced line is 1, then go to IDLE. No start edge is recognised meanwhile.
- FIFO: show-ahead. The outputs present the head entry whenever `rx_data_valid`=1. Pop occurs on `rx_data_valid & rx_data_ready`.
- Push while full: if a pop happens the same cycle, the push is accepted. Otherwise the frame is dropped and `rx_overrun` is set.
- `clr_overrun` and a dropping push in the same cycle: set wins.
- Reset mid-frame: everything returns to reset values immediately. The synchroniser reads 1, so a line that is still low produces no edge until it rises and falls again.

## Timing
- Reset values:
  - `rx_data` = 0; `rx_parity_err`, `rx_frame_err`, `rx_data_valid`, `rx_break`, `rx_overrun` = 0; `fifo_count` = 0.
  - State IDLE; FIFO pointers and entries 0.
- Start detection occurs SYNC_STAGES+1 clocks after the pin falls.
- Start sample lands `per>>1` clocks after detection; each later sample follows `per` clocks after the previous one.
- Push occurs on the clock edge after the STOP sample. `rx_data_valid` rises 1 clock after the STOP sample (registered FIFO write), and `fifo_count` updates on that same edge.
- Pop occurs at the clock edge where valid & ready are both high. The next head (or valid=0) appears the following cycle.
- `rx_break` is high for exactly one clock, coincident with the cycle after the STOP sample.
- Data outputs are don't-care while `rx_data_valid`=0, except for their reset value of 0.

## Test plan
- `cycle`=16, parity 00, DATA_BITS=8, ready held high; send 0x55 8N1. Required: `rx_data_valid` pulses one cycle with `rx_data`=0x55 and both error flags 0; the first edge of valid is 16*9+8+3 ±2 clocks after the pin falls.
- `parity_mode`=01, DATA_BITS=7, `cycle`=16; send 0x41 with parity bit 1 (wrong), then 0x41 with parity bit 0. Required: the first entry has `rx_parity_err`=1 and the second has 0; both have `rx_data`=0x41.
- Drive `rx_pin` low for 4 clocks with `cycle`=16, then high for 200 clocks. Required: no push and no flags; `fifo_count` stays 0.
- Hold `rx_pin` low for 20 bit periods, then release it; then send 0xA5. Required: `rx_break` pulses once and nothing is pushed; 0xA5 is received correctly after the release.
- FIFO_DEPTH=4, ready low; send 5 bytes 0x01..0x05. Required: `fifo_count`=4 and `rx_overrun`=1. Raising ready then yields 0x01..0x04 in order. After one `clr_overrun` pulse, `rx_overrun`=0.
- Assert `rst_n` low during data bit 3 of 0xFF, release it, then send 0x3C. Required: all outputs read 0 during reset; only 0x3C is received, with no error flags.
